toy_cpu_sequencer: RTL and testbench

- Program sequencer that sits in front of toy_cpu and drives its op_valid/opcode/src_a/src_b/dest/imm inputs.
- A short program is loaded byte-serially from pins into a local instruction buffer, then issued to the CPU one instruction at a time.
- Modes: free-run, looped, single-step. A programmable issue gap separates instructions.

---
 rtl/toy_cpu_sequencer.sv | 126 ++++++++++++
 tb/tb_toy_cpu_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/toy_cpu_sequencer.sv
// toy_cpu_sequencer: loads a short program byte-serially and issues it to toy_cpu
module toy_cpu_sequencer #(
    parameter int AW        = 3,
    parameter int ISSUE_GAP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    input  logic          load_clear,
    input  logic          start,
    input  logic          stop,
    input  logic          step,
    input  logic          loop_en,
    output logic          op_valid,
    output logic [2:0]    opcode,
    output logic [2:0]    src_a,
    output logic [2:0]    src_b,
    output logic [2:0]    dest,
    output logic [7:0]    imm,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic          load_err
);
    localparam int DEPTH = 2 ** AW;
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [AW:0]   prog_len_q;
    logic [1:0]    byte_cnt_q;
    logic [3:0]    gap_cnt_q;
    logic [5:0]    b0_q, b1_q;
    logic          load_err_q, op_valid_q, done_q;
    logic [2:0]    opcode_q, src_a_q, src_b_q, dest_q;
    logic [7:0]    imm_q;
    logic [19:0]   mem [DEPTH];
    logic [19:0]   cur;
    logic          last, has_prog, full, issue, wr_en;

    assign cur      = mem[pc_q];
    assign last     = {1'b0, pc_q} == prog_len_q - 1'b1;
    assign has_prog = prog_len_q != '0;
    assign full     = prog_len_q[AW];
    assign issue    = (state_q == RUN) ? (!stop && gap_cnt_q == 4'd0) : (!stop && !start && step && has_prog);
    assign wr_en    = state_q == IDLE && !stop && !start && !step && !load_clear && load_valid && !full && byte_cnt_q == 2'd2;

    assign op_valid = op_valid_q;
    assign opcode   = opcode_q;
    assign src_a    = src_a_q;
    assign src_b    = src_b_q;
    assign dest     = dest_q;
    assign imm      = imm_q;
    assign busy     = state_q == RUN;
    assign done     = done_q;
    assign pc       = pc_q;
    assign load_err = load_err_q;

    // Instruction buffer: a completed 3-byte instruction is stored as {B0[7:2], B1[7:2], B2}
    always_ff @(posedge clk) begin
        if (wr_en) mem[prog_len_q[AW-1:0]] <= {b0_q, b1_q, load_data};
    end

    // Sequencing FSM, byte loader and registered CPU-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            prog_len_q <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            load_err_q <= 1'b0;
            op_valid_q <= 1'b0;
            done_q     <= 1'b0;
            opcode_q   <= '0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            dest_q     <= '0;
            imm_q      <= '0;
        end else begin
            op_valid_q <= issue;
            opcode_q   <= issue ? cur[19:17] : 3'd0;
            dest_q     <= issue ? cur[16:14] : 3'd0;
            src_a_q    <= issue ? cur[13:11] : 3'd0;
            src_b_q    <= issue ? cur[10:8]  : 3'd0;
            imm_q      <= issue ? cur[7:0]   : 8'd0;
            done_q     <= issue && last && (state_q == IDLE || !loop_en);
            if (state_q == RUN) begin
                if (load_valid) load_err_q <= 1'b1;
                if (stop) state_q <= IDLE;
                else if (gap_cnt_q != 4'd0) gap_cnt_q <= gap_cnt_q - 4'd1;
                else begin
                    gap_cnt_q <= 4'(ISSUE_GAP);
                    pc_q      <= last ? '0 : pc_q + 1'b1;
                    if (last && !loop_en) state_q <= IDLE;
                end
            end else if (!stop) begin
                if (start) begin
                    if (has_prog) begin
                        state_q    <= RUN;
                        pc_q       <= '0;
                        gap_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                    end
                end else if (step) begin
                    if (has_prog) pc_q <= last ? '0 : pc_q + 1'b1;
                end else if (load_clear) begin
                    prog_len_q <= '0;
                    byte_cnt_q <= '0;
                    load_err_q <= 1'b0;
                    pc_q       <= '0;
                end else if (load_valid) begin
                    if (full) load_err_q <= 1'b1;
                    else begin
                        byte_cnt_q <= (byte_cnt_q == 2'd2) ? 2'd0 : byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd0) b0_q <= load_data[7:2];
                        if (byte_cnt_q == 2'd1) b1_q <= load_data[7:2];
                        if (byte_cnt_q == 2'd2) prog_len_q <= prog_len_q + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_toy_cpu_sequencer.sv
// tb_toy_cpu_sequencer: two sequencers (issue gap 0 and 3) checked against a byte-level program model
module tb_toy_cpu_sequencer;
    logic       clk = 1'b0, rst = 1'b1;
    logic       load_valid = 1'b0, load_clear = 1'b0, start = 1'b0, stop = 1'b0, step = 1'b0, loop_en = 1'b0;
    logic [7:0] load_data = 8'd0;
    logic       ov[2], dn[2], bz[2], er[2];
    logic [2:0] opc[2], sa[2], sb[2], ds[2], pcv[2];
    logic [7:0] im[2];

    int checks = 0, errors = 0, cyc = 0;
    int n_op[2], n_done[2];

    logic [7:0]  m_mem[2][24];
    int          m_len[2], m_nb[2], m_pc[2], m_wait[2];
    bit          m_run[2], m_err[2];
    logic [26:0] m_exp[2];

    always #5 clk = ~clk;

    toy_cpu_sequencer #(.AW(3), .ISSUE_GAP(0)) u0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_clear(load_clear),
        .start(start), .stop(stop), .step(step), .loop_en(loop_en), .op_valid(ov[0]), .opcode(opc[0]),
        .src_a(sa[0]), .src_b(sb[0]), .dest(ds[0]), .imm(im[0]), .busy(bz[0]), .done(dn[0]), .pc(pcv[0]),
        .load_err(er[0]));

    toy_cpu_sequencer #(.AW(3), .ISSUE_GAP(3)) u1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_clear(load_clear),
        .start(start), .stop(stop), .step(step), .loop_en(loop_en), .op_valid(ov[1]), .opcode(opc[1]),
        .src_a(sa[1]), .src_b(sb[1]), .dest(ds[1]), .imm(im[1]), .busy(bz[1]), .done(dn[1]), .pc(pcv[1]),
        .load_err(er[1]));

    function automatic logic [26:0] got(input int k);
        return {ov[k], opc[k], sa[k], sb[k], ds[k], im[k], dn[k], bz[k], pcv[k], er[k]};
    endfunction

    // Program held as raw bytes; fields are decoded from bytes only when an instruction issues
    task automatic model_edge(input int k);
        int         g   = (k == 0) ? 0 : 3;
        int         idx = m_pc[k];
        bit         ev  = 0, ed = 0;
        logic [7:0] b0 = 8'd0, b1 = 8'd0, b2 = 8'd0;
        if (rst) begin
            m_run[k] = 0; m_pc[k] = 0; m_len[k] = 0; m_nb[k] = 0; m_wait[k] = 0; m_err[k] = 0;
        end else if (m_run[k]) begin
            if (load_valid) m_err[k] = 1;
            if (stop) m_run[k] = 0;
            else if (m_wait[k] > 0) m_wait[k]--;
            else begin
                ev = 1;
                m_wait[k] = g;
                m_pc[k] = (idx + 1) % m_len[k];
                if (idx == m_len[k] - 1 && !loop_en) begin
                    ed = 1;
                    m_run[k] = 0;
                end
            end
        end else if (!stop) begin
            if (start) begin
                if (m_len[k] > 0) begin
                    m_run[k] = 1; m_pc[k] = 0; m_wait[k] = 0; m_nb[k] = 0;
                end
            end else if (step) begin
                if (m_len[k] > 0) begin
                    ev = 1;
                    ed = (idx == m_len[k] - 1);
                    m_pc[k] = (idx + 1) % m_len[k];
                end
            end else if (load_clear) begin
                m_len[k] = 0; m_nb[k] = 0; m_err[k] = 0; m_pc[k] = 0;
            end else if (load_valid) begin
                if (m_len[k] == 8) m_err[k] = 1;
                else begin
                    m_mem[k][m_len[k] * 3 + m_nb[k]] = load_data;
                    if (m_nb[k] == 2) begin
                        m_len[k]++;
                        m_nb[k] = 0;
                    end else m_nb[k]++;
                end
            end
        end
        if (ev) begin
            b0 = m_mem[k][idx * 3];
            b1 = m_mem[k][idx * 3 + 1];
            b2 = m_mem[k][idx * 3 + 2];
        end
        m_exp[k] = {ev, b0[7:5], b1[7:5], b1[4:2], b0[4:2], b2, ed, m_run[k], 3'(m_pc[k]), m_err[k]};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            assert (got(k) === m_exp[k]) else begin
                errors++;
                $error("FAIL cycle%0d dut%0d outputs got=%h exp=%h", cyc, k, got(k), m_exp[k]);
            end
            n_op[k]   += int'(ov[k]);
            n_done[k] += int'(dn[k]);
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero();
        n_op = '{0, 0};
        n_done = '{0, 0};
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic put(input logic [7:0] b);
        load_valid = 1'b1;
        load_data = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic cmd(input logic s, input logic p, input logic t);
        start = s; stop = p; step = t;
        tick();
        start = 1'b0; stop = 1'b0; step = 1'b0;
    endtask

    task automatic clr();
        load_clear = 1'b1;
        tick();
        load_clear = 1'b0;
    endtask

    task automatic load_prog2();
        put(8'hE0); put(8'h00); put(8'h05);
        put(8'h24); put(8'h20); put(8'h00);
    endtask

    initial begin
        idle(2);
        chk("reset_u0", 32'(got(0)), 32'd0);
        chk("reset_u1", 32'(got(1)), 32'd0);
        rst = 1'b0;
        load_prog2();
        zero();
        cmd(1, 0, 0);
        idle(12);
        chk("run_ops_u0", n_op[0], 2);
        chk("run_done_u0", n_done[0], 1);
        chk("run_ops_u1", n_op[1], 2);
        chk("run_done_u1", n_done[1], 1);
        chk("run_end_busy_pc", {bz[0], pcv[0]}, 0);
        loop_en = 1'b1;
        cmd(1, 0, 0);
        zero();
        idle(20);
        chk("loop_ops_u0", n_op[0], 20);
        chk("loop_ops_u1", n_op[1], 5);
        chk("loop_done", n_done[0] + n_done[1], 0);
        cmd(0, 1, 0);
        chk("stop_u0", {ov[0], bz[0]}, 0);
        chk("stop_u1", {ov[1], bz[1]}, 0);
        loop_en = 1'b0;
        clr();
        repeat (24) put(8'($urandom));
        put(8'h5A);
        chk("overflow_err", {er[0], er[1]}, 2'b11);
        zero();
        cmd(1, 0, 0);
        idle(36);
        chk("full_ops_u0", n_op[0], 8);
        chk("full_ops_u1", n_op[1], 8);
        chk("full_done_u1", n_done[1], 1);
        clr();
        chk("clear_err", {er[0], er[1]}, 0);
        cmd(1, 0, 0);
        chk("empty_start", {bz[0], bz[1]}, 0);
        load_prog2();
        zero();
        repeat (3) begin
            cmd(0, 0, 1);
            idle(1);
        end
        chk("step_ops", n_op[0] + n_op[1], 6);
        chk("step_done", n_done[0] + n_done[1], 2);
        cmd(1, 1, 0);
        chk("start_stop", {bz[0], bz[1]}, 0);
        cmd(1, 0, 0);
        put(8'hAA);
        chk("run_load_err", {er[0], er[1]}, 2'b11);
        idle(12);
        clr();
        load_prog2();
        put(8'h11);
        put(8'h22);
        zero();
        cmd(1, 0, 0);
        idle(12);
        chk("partial_ops", n_op[0] + n_op[1], 4);
        chk("partial_done", n_done[0] + n_done[1], 2);
        loop_en = 1'b1;
        cmd(1, 0, 0);
        idle(5);
        rst = 1'b1;
        tick();
        chk("midrun_rst_u0", 32'(got(0)), 32'd0);
        chk("midrun_rst_u1", 32'(got(1)), 32'd0);
        rst = 1'b0;
        repeat (1500) begin
            rst        = ($urandom % 200) == 0;
            stop       = ($urandom % 30) == 0;
            start      = ($urandom % 12) == 0;
            step       = ($urandom % 8) == 0;
            load_clear = ($urandom % 50) == 0;
            load_valid = ($urandom % 3) == 0;
            load_data  = 8'($urandom);
            if ($urandom % 40 == 0) loop_en = ~loop_en;
            tick();
        end
        {rst, stop, start, step, load_clear, load_valid} = '0;
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
